// File: rtl/dnn_layer_sequencer_if.sv
// Handshake/bus bundle between the layer sequencer and its neighbours.
//  Config port : cfg_valid/cfg_ready, cfg_k_len, cfg_num_tiles, abort
//  Fetch port  : fetch_valid, act_ready, wt_ready, act_addr, wt_addr
//  PE control  : pe_clear, pe_mac_en, pe_mac_last
//  Output port : of_valid, of_ready, of_row
//  Status      : tile_idx, busy, done
// The master modport is the sequencer side; the slave modport is the environment side.
interface dnn_layer_sequencer_if #(
    parameter int Y_DIM  = 16,
    parameter int ADDR_W = 12,
    parameter int K_W    = 8,
    parameter int T_W    = 8
);
    localparam int ROW_W = (Y_DIM > 1) ? $clog2(Y_DIM) : 1;

    logic              cfg_valid;
    logic              cfg_ready;
    logic [K_W-1:0]    cfg_k_len;
    logic [T_W-1:0]    cfg_num_tiles;
    logic              abort;
    logic              fetch_valid;
    logic              act_ready;
    logic              wt_ready;
    logic [ADDR_W-1:0] act_addr;
    logic [ADDR_W-1:0] wt_addr;
    logic              pe_clear;
    logic              pe_mac_en;
    logic              pe_mac_last;
    logic              of_valid;
    logic              of_ready;
    logic [ROW_W-1:0]  of_row;
    logic [T_W-1:0]    tile_idx;
    logic              busy;
    logic              done;

    modport master (
        input  cfg_valid, cfg_k_len, cfg_num_tiles, abort, act_ready, wt_ready, of_ready,
        output cfg_ready, fetch_valid, act_addr, wt_addr, pe_clear, pe_mac_en, pe_mac_last,
               of_valid, of_row, tile_idx, busy, done
    );

    modport slave (
        output cfg_valid, cfg_k_len, cfg_num_tiles, abort, act_ready, wt_ready, of_ready,
        input  cfg_ready, fetch_valid, act_addr, wt_addr, pe_clear, pe_mac_en, pe_mac_last,
               of_valid, of_row, tile_idx, busy, done
    );
endinterface

// File: rtl/dnn_layer_sequencer.sv
// Layer-level scheduler for the PE array. Accepts one layer config (K, T), then for each
// output tile: clears the accumulators, issues K lockstep act/wt fetch steps, waits for the
// fetch + PE pipeline to flush, and drains Y_DIM output rows. Pulses done at completion.
// Ports:
//  clk  - clock
//  rst  - synchronous reset, active-low
//  bus  - dnn_layer_sequencer_if.master (config, fetch, PE control, output and status)
// All outputs are registered; they are computed from the next-state values.
module dnn_layer_sequencer #(
    parameter int Y_DIM     = 16,
    parameter int ADDR_W    = 12,
    parameter int K_W       = 8,
    parameter int T_W       = 8,
    parameter int FETCH_LAT = 2,
    parameter int PE_LAT    = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    dnn_layer_sequencer_if.master bus
);
    localparam int ROW_W = (Y_DIM > 1) ? $clog2(Y_DIM) : 1;
    localparam int FL_W  = $clog2(FETCH_LAT + PE_LAT + 1);
    localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(Y_DIM - 1);
    localparam logic [FL_W-1:0]  FLUSH_LAST = FL_W'(FETCH_LAT + PE_LAT - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_FETCH = 3'd2;
    localparam logic [2:0] S_FLUSH = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;
    localparam logic [2:0] S_FIN   = 3'd5;

    logic [2:0]          state_r, state_nxt_s;
    logic [K_W-1:0]      k_r, k_nxt_s, k_len_r, k_len_nxt_s;
    logic [T_W-1:0]      tile_r, tile_nxt_s, num_tiles_r, num_tiles_nxt_s;
    logic [ADDR_W-1:0]   base_r, base_nxt_s;
    logic [ROW_W-1:0]    row_r, row_nxt_s;
    logic [FL_W-1:0]     flush_r, flush_nxt_s;
    logic [FETCH_LAT-1:0] mac_en_pipe_r, mac_last_pipe_r;

    logic abort_s, accept_s, last_k_s, last_tile_s;

    logic              cfg_ready_r, fetch_valid_r, pe_clear_r, of_valid_r, busy_r, done_r;
    logic [ADDR_W-1:0] act_addr_r, wt_addr_r;
    logic [ROW_W-1:0]  of_row_r;
    logic [T_W-1:0]    tile_idx_r;

    // Abort only acts outside IDLE; in IDLE it is ignored.
    assign abort_s     = bus.abort && (state_r != S_IDLE);
    assign last_k_s    = (k_r == (k_len_r - K_W'(1)));
    assign last_tile_s = (tile_r == (num_tiles_r - T_W'(1)));

    // Next-state and counter update logic; abort has priority over every handshake.
    always_comb begin
        state_nxt_s     = state_r;
        k_nxt_s         = k_r;
        k_len_nxt_s     = k_len_r;
        tile_nxt_s      = tile_r;
        num_tiles_nxt_s = num_tiles_r;
        base_nxt_s      = base_r;
        row_nxt_s       = row_r;
        flush_nxt_s     = flush_r;
        accept_s        = 1'b0;
        if (abort_s) begin
            state_nxt_s = S_IDLE;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (bus.cfg_valid) begin
                        k_len_nxt_s     = bus.cfg_k_len;
                        num_tiles_nxt_s = bus.cfg_num_tiles;
                        tile_nxt_s      = '0;
                        base_nxt_s      = '0;
                        k_nxt_s         = '0;
                        row_nxt_s       = '0;
                        if ((bus.cfg_k_len == K_W'(0)) || (bus.cfg_num_tiles == T_W'(0))) begin
                            state_nxt_s = S_FIN;
                        end else begin
                            state_nxt_s = S_CLEAR;
                        end
                    end else begin
                        state_nxt_s = S_IDLE;
                    end
                end
                S_CLEAR: begin
                    k_nxt_s     = '0;
                    state_nxt_s = S_FETCH;
                end
                S_FETCH: begin
                    // A step only counts when both fetchers take it in the same cycle.
                    if (bus.act_ready && bus.wt_ready) begin
                        accept_s = 1'b1;
                        if (last_k_s) begin
                            flush_nxt_s = '0;
                            state_nxt_s = S_FLUSH;
                        end else begin
                            k_nxt_s = k_r + K_W'(1);
                        end
                    end else begin
                        state_nxt_s = S_FETCH;
                    end
                end
                S_FLUSH: begin
                    if (flush_r == FLUSH_LAST) begin
                        row_nxt_s   = '0;
                        state_nxt_s = S_DRAIN;
                    end else begin
                        flush_nxt_s = flush_r + FL_W'(1);
                    end
                end
                S_DRAIN: begin
                    if (bus.of_ready) begin
                        if (row_r == ROW_LAST) begin
                            if (last_tile_s) begin
                                state_nxt_s = S_FIN;
                            end else begin
                                // tile*K kept as a running sum, wrapping at 2^ADDR_W.
                                tile_nxt_s  = tile_r + T_W'(1);
                                base_nxt_s  = base_r + ADDR_W'(k_len_r);
                                state_nxt_s = S_CLEAR;
                            end
                        end else begin
                            row_nxt_s = row_r + ROW_W'(1);
                        end
                    end else begin
                        state_nxt_s = S_DRAIN;
                    end
                end
                S_FIN: begin
                    state_nxt_s = S_IDLE;
                end
                default: begin
                    state_nxt_s = S_IDLE;
                end
            endcase
        end
    end

    // State, counters and latched layer configuration.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r     <= S_IDLE;
            k_r         <= '0;
            k_len_r     <= '0;
            tile_r      <= '0;
            num_tiles_r <= '0;
            base_r      <= '0;
            row_r       <= '0;
            flush_r     <= '0;
        end else begin
            state_r     <= state_nxt_s;
            k_r         <= k_nxt_s;
            k_len_r     <= k_len_nxt_s;
            tile_r      <= tile_nxt_s;
            num_tiles_r <= num_tiles_nxt_s;
            base_r      <= base_nxt_s;
            row_r       <= row_nxt_s;
            flush_r     <= flush_nxt_s;
        end
    end

    // MAC-enable delay line matching the fetch latency; flushed on abort so no stale MACs fire.
    always_ff @(posedge clk) begin
        if (!rst || abort_s) begin
            mac_en_pipe_r   <= '0;
            mac_last_pipe_r <= '0;
        end else begin
            for (int i = FETCH_LAT - 1; i > 0; i--) begin
                mac_en_pipe_r[i]   <= mac_en_pipe_r[i-1];
                mac_last_pipe_r[i] <= mac_last_pipe_r[i-1];
            end
            mac_en_pipe_r[0]   <= accept_s;
            mac_last_pipe_r[0] <= accept_s && last_k_s;
        end
    end

    // Registered outputs decoded from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cfg_ready_r   <= 1'b1;
            busy_r        <= 1'b0;
            fetch_valid_r <= 1'b0;
            pe_clear_r    <= 1'b0;
            of_valid_r    <= 1'b0;
            done_r        <= 1'b0;
            of_row_r      <= '0;
            tile_idx_r    <= '0;
            act_addr_r    <= '0;
            wt_addr_r     <= '0;
        end else begin
            cfg_ready_r   <= (state_nxt_s == S_IDLE);
            busy_r        <= (state_nxt_s != S_IDLE);
            fetch_valid_r <= (state_nxt_s == S_FETCH);
            pe_clear_r    <= (state_nxt_s == S_CLEAR);
            of_valid_r    <= (state_nxt_s == S_DRAIN);
            done_r        <= (state_nxt_s == S_FIN);
            of_row_r      <= row_nxt_s;
            tile_idx_r    <= tile_nxt_s;
            act_addr_r    <= base_nxt_s + ADDR_W'(k_nxt_s);
            wt_addr_r     <= ADDR_W'(k_nxt_s);
        end
    end

    assign bus.cfg_ready   = cfg_ready_r;
    assign bus.busy        = busy_r;
    assign bus.fetch_valid = fetch_valid_r;
    assign bus.pe_clear    = pe_clear_r;
    assign bus.of_valid    = of_valid_r;
    assign bus.done        = done_r;
    assign bus.of_row      = of_row_r;
    assign bus.tile_idx    = tile_idx_r;
    assign bus.act_addr    = act_addr_r;
    assign bus.wt_addr     = wt_addr_r;
    assign bus.pe_mac_en   = mac_en_pipe_r[FETCH_LAT-1];
    assign bus.pe_mac_last = mac_last_pipe_r[FETCH_LAT-1];
endmodule
